// File: rtl/wb2axil_master_bridge.sv
// wb2axil_master_bridge
//   Pipelined Wishbone slave to AXI4-Lite master bridge. Exactly one
//   transaction is in flight; every AXI response becomes a single
//   wb_ack_o (OKAY/EXOKAY) or wb_err_o (SLVERR/DECERR) pulse.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   wb_*                    Wishbone pipelined slave (word address)
//   o_axi_aw*/o_axi_w*/b*   AXI4-Lite write channels (byte address)
//   o_axi_ar*/r*            AXI4-Lite read channels
module wb2axil_master_bridge #(
  parameter int unsigned C_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wb_cyc_i,
  input  logic                          wb_stb_i,
  input  logic                          wb_we_i,
  input  logic [C_AXI_ADDR_WIDTH-3:0]   wb_adr_i,
  input  logic [C_AXI_DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] wb_sel_i,
  output logic [C_AXI_DATA_WIDTH-1:0]   wb_dat_o,
  output logic                          wb_ack_o,
  output logic                          wb_err_o,
  output logic                          wb_stall_o,
  output logic                          o_axi_awvalid,
  input  logic                          i_axi_awready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   o_axi_awaddr,
  output logic [2:0]                    o_axi_awprot,
  output logic                          o_axi_wvalid,
  input  logic                          i_axi_wready,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] o_axi_wstrb,
  input  logic                          i_axi_bvalid,
  output logic                          o_axi_bready,
  input  logic [1:0]                    i_axi_bresp,
  output logic                          o_axi_arvalid,
  input  logic                          i_axi_arready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   o_axi_araddr,
  output logic [2:0]                    o_axi_arprot,
  input  logic                          i_axi_rvalid,
  output logic                          o_axi_rready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_rdata,
  input  logic [1:0]                    i_axi_rresp
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WR_RESP, S_READ, S_RD_DATA, S_DONE
  } state_e;

  state_e                        state_q, state_d;
  logic [C_AXI_ADDR_WIDTH-3:0]   adr_q, adr_d;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [C_AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [C_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          arvalid_q, arvalid_d;
  logic                          err_q, err_d;
  // Set when the master drops wb_cyc_i mid-transaction: the AXI side still
  // runs to completion but the final ack/err pulse is swallowed.
  logic                          abort_q, abort_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      adr_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      err_q     <= err_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    err_d     = err_q;
    abort_d   = abort_q;

    unique case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d   = wb_adr_i;
          wdata_d = wb_dat_i;
          wstrb_d = wb_sel_i;
          err_d   = 1'b0;
          abort_d = 1'b0;
          if (wb_we_i) begin
            state_d   = S_WRITE;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_READ;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        // AW and W retire independently; leave only when both have.
        if (awvalid_q && i_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && i_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (i_axi_bvalid) begin
          err_d   = i_axi_bresp[1];
          state_d = S_DONE;
        end
      end
      S_READ: begin
        if (i_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (i_axi_rvalid) begin
          rdata_d = i_axi_rdata;
          err_d   = i_axi_rresp[1];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && state_q != S_DONE && !wb_cyc_i) abort_d = 1'b1;
  end

  assign wb_dat_o      = rdata_q;
  assign wb_stall_o    = (state_q != S_IDLE);
  assign wb_ack_o      = (state_q == S_DONE) && wb_cyc_i && !abort_q && !err_q;
  assign wb_err_o      = (state_q == S_DONE) && wb_cyc_i && !abort_q && err_q;

  assign o_axi_awvalid = awvalid_q;
  assign o_axi_awaddr  = {adr_q, 2'b00};
  assign o_axi_awprot  = 3'b000;
  assign o_axi_wvalid  = wvalid_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wstrb   = wstrb_q;
  assign o_axi_bready  = (state_q == S_WR_RESP);
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_araddr  = {adr_q, 2'b00};
  assign o_axi_arprot  = 3'b000;
  assign o_axi_rready  = (state_q == S_RD_DATA);

endmodule

// File: tb/tb_wb2axil_master_bridge.sv
// Testbench for wb2axil_master_bridge: directed Wishbone transactions with a
// hand-driven AXI4-Lite slave; responses are checked by a scoreboard monitor.
module tb_wb2axil_master_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [29:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_stall_o;
  logic        o_axi_awvalid, i_axi_awready;
  logic [31:0] o_axi_awaddr;
  logic [2:0]  o_axi_awprot;
  logic        o_axi_wvalid, i_axi_wready;
  logic [31:0] o_axi_wdata;
  logic [3:0]  o_axi_wstrb;
  logic        i_axi_bvalid, o_axi_bready;
  logic [1:0]  i_axi_bresp;
  logic        o_axi_arvalid, i_axi_arready;
  logic [31:0] o_axi_araddr;
  logic [2:0]  o_axi_arprot;
  logic        i_axi_rvalid, o_axi_rready;
  logic [31:0] i_axi_rdata;
  logic [1:0]  i_axi_rresp;

  wb2axil_master_bridge #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_stall_o(wb_stall_o),
    .o_axi_awvalid(o_axi_awvalid), .i_axi_awready(i_axi_awready),
    .o_axi_awaddr(o_axi_awaddr), .o_axi_awprot(o_axi_awprot),
    .o_axi_wvalid(o_axi_wvalid), .i_axi_wready(i_axi_wready),
    .o_axi_wdata(o_axi_wdata), .o_axi_wstrb(o_axi_wstrb),
    .i_axi_bvalid(i_axi_bvalid), .o_axi_bready(o_axi_bready),
    .i_axi_bresp(i_axi_bresp),
    .o_axi_arvalid(o_axi_arvalid), .i_axi_arready(i_axi_arready),
    .o_axi_araddr(o_axi_araddr), .o_axi_arprot(o_axi_arprot),
    .i_axi_rvalid(i_axi_rvalid), .o_axi_rready(o_axi_rready),
    .i_axi_rdata(i_axi_rdata), .i_axi_rresp(i_axi_rresp)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        err;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard monitor: every ack/err pulse must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && (wb_ack_o || wb_err_o)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got ack=%0b err=%0b expected no response at %0t",
                 wb_ack_o, wb_err_o, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_err", 32'(wb_err_o), 32'(e.err));
        chk("resp_ack", 32'(wb_ack_o), 32'(!e.err));
        if (e.chk_data) chk("resp_data", wb_dat_o, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Start of a new cycle: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    i_axi_awready = 0; i_axi_wready = 0; i_axi_bvalid = 0; i_axi_bresp = 2'b00;
    i_axi_arready = 0; i_axi_rvalid = 0; i_axi_rdata = '0; i_axi_rresp = 2'b00;
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    step(); step();
    #2;
    chk("rst_stall",   32'(wb_stall_o),    0);
    chk("rst_awvalid", 32'(o_axi_awvalid), 0);
    chk("rst_arvalid", 32'(o_axi_arvalid), 0);
    chk("rst_dat",     wb_dat_o,           0);
    rst_ni = 1'b1;

    // 1: write, everything immediate; stray bvalid in IDLE/WRITE must be ignored
    step();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 30'h104;
    wb_dat_i = 32'hDEAD_BEEF; wb_sel_i = 4'hF;
    i_axi_awready = 1; i_axi_wready = 1; i_axi_bvalid = 1; i_axi_bresp = 2'b00;
    #2;
    chk("t1_c0_stall", 32'(wb_stall_o), 0);
    chk("t1_c0_bready", 32'(o_axi_bready), 0);
    sb.push_back('{err: 1'b0, chk_data: 1'b0, data: 32'h0});
    step(); wb_stb_i = 0; #2;
    chk("t1_c1_awvalid", 32'(o_axi_awvalid), 1);
    chk("t1_c1_wvalid",  32'(o_axi_wvalid),  1);
    chk("t1_awaddr",     o_axi_awaddr,       32'h0000_0410);
    chk("t1_wdata",      o_axi_wdata,        32'hDEAD_BEEF);
    chk("t1_wstrb",      32'(o_axi_wstrb),   32'hF);
    chk("t1_c1_stall",   32'(wb_stall_o),    1);
    chk("t1_c1_bready",  32'(o_axi_bready),  0);
    step(); #2;
    chk("t1_c2_awvalid", 32'(o_axi_awvalid), 0);
    chk("t1_c2_wvalid",  32'(o_axi_wvalid),  0);
    chk("t1_c2_bready",  32'(o_axi_bready),  1);
    chk("t1_c2_stall",   32'(wb_stall_o),    1);
    step(); #2;
    chk("t1_c3_ack",     32'(wb_ack_o),      1);
    chk("t1_c3_stall",   32'(wb_stall_o),    1);
    step(); idle_inputs(); #2;
    chk("t1_idle_stall", 32'(wb_stall_o),    0);

    // 2: write, W accepted 3 cycles before AW, sel=0, SLVERR
    step();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 30'h200;
    wb_dat_i = 32'h0102_0304; wb_sel_i = 4'h0;
    #2;
    sb.push_back('{err: 1'b1, chk_data: 1'b0, data: 32'h0});
    step(); wb_stb_i = 0; i_axi_wready = 1; #2;
    chk("t2_c1_wvalid",  32'(o_axi_wvalid),  1);
    chk("t2_c1_awvalid", 32'(o_axi_awvalid), 1);
    chk("t2_wstrb_zero", 32'(o_axi_wstrb),   0);
    step(); i_axi_wready = 0; #2;
    chk("t2_c2_wvalid",  32'(o_axi_wvalid),  0);
    chk("t2_c2_awvalid", 32'(o_axi_awvalid), 1);
    step(); #2;
    chk("t2_c3_awvalid", 32'(o_axi_awvalid), 1);
    chk("t2_c3_bready",  32'(o_axi_bready),  0);
    step(); i_axi_awready = 1; #2;
    chk("t2_c4_awvalid", 32'(o_axi_awvalid), 1);
    step(); i_axi_awready = 0; i_axi_bvalid = 1; i_axi_bresp = 2'b10; #2;
    chk("t2_c5_awvalid", 32'(o_axi_awvalid), 0);
    chk("t2_c5_bready",  32'(o_axi_bready),  1);
    step(); i_axi_bvalid = 0; #2;
    chk("t2_c6_err",     32'(wb_err_o),      1);
    chk("t2_c6_ack",     32'(wb_ack_o),      0);
    step(); idle_inputs();

    // 3: read 0x20, arready after 5 cycles; early rvalid ignored in READ
    step();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 30'h8;
    i_axi_rvalid = 1; i_axi_rdata = 32'h1234_5678; i_axi_rresp = 2'b00;
    #2;
    chk("t3_c0_rready", 32'(o_axi_rready), 0);
    sb.push_back('{err: 1'b0, chk_data: 1'b1, data: 32'h1234_5678});
    for (int i = 1; i <= 5; i++) begin
      step();
      wb_stb_i = 0;
      if (i == 5) i_axi_arready = 1;
      #2;
      chk("t3_arvalid", 32'(o_axi_arvalid), 1);
      chk("t3_rready",  32'(o_axi_rready),  0);
    end
    chk("t3_araddr", o_axi_araddr, 32'h0000_0020);
    step(); i_axi_arready = 0; #2;
    chk("t3_c6_arvalid", 32'(o_axi_arvalid), 0);
    chk("t3_c6_rready",  32'(o_axi_rready),  1);
    step(); i_axi_rvalid = 0; #2;
    chk("t3_c7_ack", 32'(wb_ack_o), 1);
    chk("t3_c7_dat", wb_dat_o, 32'h1234_5678);
    step(); idle_inputs();

    // 4: read with DECERR; data still captured
    step();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 30'h10;
    i_axi_arready = 1; i_axi_rvalid = 1; i_axi_rdata = 32'hAAAA_5555; i_axi_rresp = 2'b11;
    #2;
    sb.push_back('{err: 1'b1, chk_data: 1'b1, data: 32'hAAAA_5555});
    step(); wb_stb_i = 0; #2;
    chk("t4_c1_arvalid", 32'(o_axi_arvalid), 1);
    step(); #2;
    chk("t4_c2_rready", 32'(o_axi_rready), 1);
    step(); i_axi_arready = 0; i_axi_rvalid = 0; #2;
    chk("t4_c3_err", 32'(wb_err_o), 1);
    chk("t4_c3_dat", wb_dat_o, 32'hAAAA_5555);
    step(); idle_inputs();

    // 5: write abandoned in WR_RESP; new read held on stb meanwhile
    step();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 30'hC0;
    wb_dat_i = 32'h0000_0055; wb_sel_i = 4'h3;
    i_axi_awready = 1; i_axi_wready = 1;
    step(); wb_stb_i = 0;
    step(); wb_cyc_i = 0; #2;
    chk("t5_c2_bready", 32'(o_axi_bready), 1);
    step(); #2; chk("t5_c3_bready", 32'(o_axi_bready), 1);
    step(); #2; chk("t5_c4_bready", 32'(o_axi_bready), 1);
    step();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 30'h44;
    #2;
    chk("t5_c5_bready", 32'(o_axi_bready), 1);
    chk("t5_c5_stall",  32'(wb_stall_o),   1);
    step(); i_axi_bvalid = 1; i_axi_bresp = 2'b00; #2;
    chk("t5_c6_bready", 32'(o_axi_bready), 1);
    step(); i_axi_bvalid = 0; #2;
    chk("t5_c7_ack",   32'(wb_ack_o),   0);
    chk("t5_c7_err",   32'(wb_err_o),   0);
    chk("t5_c7_stall", 32'(wb_stall_o), 1);
    step();
    i_axi_arready = 1; i_axi_rvalid = 1; i_axi_rdata = 32'h0BAD_F00D; i_axi_rresp = 2'b01;
    #2;
    chk("t5_c8_stall",   32'(wb_stall_o), 0);
    chk("t5_dat_hold",   wb_dat_o,        32'hAAAA_5555);
    sb.push_back('{err: 1'b0, chk_data: 1'b1, data: 32'h0BAD_F00D});
    step(); wb_stb_i = 0; #2;
    chk("t5_c9_arvalid", 32'(o_axi_arvalid), 1);
    chk("t5_araddr",     o_axi_araddr,       32'h0000_0110);
    step(); #2;
    chk("t5_c10_rready", 32'(o_axi_rready), 1);
    step(); i_axi_arready = 0; i_axi_rvalid = 0; #2;
    chk("t5_c11_ack", 32'(wb_ack_o), 1);
    step(); idle_inputs();

    // 6: asynchronous reset while AW/W are pending
    step();
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 1; wb_adr_i = 30'h1;
    wb_dat_i = 32'hCAFE_0001; wb_sel_i = 4'hF;
    step(); wb_stb_i = 0; #2;
    chk("t6_pre_awvalid", 32'(o_axi_awvalid), 1);
    rst_ni = 1'b0;
    #1;
    chk("t6_awvalid", 32'(o_axi_awvalid), 0);
    chk("t6_wvalid",  32'(o_axi_wvalid),  0);
    chk("t6_stall",   32'(wb_stall_o),    0);
    chk("t6_dat",     wb_dat_o,           0);
    step(); wb_cyc_i = 0; #2; rst_ni = 1'b1;
    step(); #2;
    chk("t6_post_stall",   32'(wb_stall_o),    0);
    chk("t6_post_awvalid", 32'(o_axi_awvalid), 0);

    step(); step();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb2axil_master_bridge.md
Name: wb2axil_master_bridge

Overview:
Wishbone (pipelined-mode) slave to AXI4-Lite master bridge. It carries CPU-side or peripheral Wishbone cycles out onto an AXI4-Lite interconnect. This is the reverse direction of the existing AXI4-Lite-to-Wishbone core wrappers. It supports one outstanding transaction and converts AXI responses into Wishbone ack/err.

Parameters:
C_AXI_DATA_WIDTH, 32, width of the AXI and Wishbone data buses.
C_AXI_ADDR_WIDTH, 32, AXI byte-address width. The Wishbone word address is C_AXI_ADDR_WIDTH-2 bits wide.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_ni  in  1  asynchronous, active-low reset.
wb_cyc_i  in  1  Wishbone cycle.
wb_stb_i  in  1  Wishbone strobe.
wb_we_i  in  1  1 = write, 0 = read.
wb_adr_i  in  C_AXI_ADDR_WIDTH-2  word address.
wb_dat_i  in  C_AXI_DATA_WIDTH  write data.
wb_sel_i  in  C_AXI_DATA_WIDTH/8  byte selects.
wb_dat_o  out  C_AXI_DATA_WIDTH  read data.
wb_ack_o  out  1  one-cycle success pulse.
wb_err_o  out  1  one-cycle error pulse.
wb_stall_o  out  1  request not accepted this cycle.
o_axi_awvalid  out  1  write address valid.
i_axi_awready  in  1  write address ready.
o_axi_awaddr  out  C_AXI_ADDR_WIDTH  write byte address.
o_axi_awprot  out  3  constant 3'b000.
o_axi_wvalid  out  1  write data valid.
i_axi_wready  in  1  write data ready.
o_axi_wdata  out  C_AXI_DATA_WIDTH  write data.
o_axi_wstrb  out  C_AXI_DATA_WIDTH/8  write strobes.
i_axi_bvalid  in  1  write response valid.
o_axi_bready  out  1  write response ready.
i_axi_bresp  in  2  write response.
o_axi_arvalid  out  1  read address valid.
i_axi_arready  in  1  read address ready.
o_axi_araddr  out  C_AXI_ADDR_WIDTH  read byte address.
o_axi_arprot  out  3  constant 3'b000.
i_axi_rvalid  in  1  read data valid.
o_axi_rready  out  1  read data ready.
i_axi_rdata  in  C_AXI_DATA_WIDTH  read data.
i_axi_rresp  in  2  read response.

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE; all valid/ready/ack/err outputs 0; wb_dat_o 0; address/data/strobe registers 0.
- States:
  - IDLE, WRITE (AW/W phase), WR_RESP, READ (AR phase), RD_DATA, DONE.
  - wb_stall_o = (state != IDLE).
- Accept:
  - In IDLE, cyc&stb sets the accept condition.
  - On accept, register {wb_adr_i,2'b00} into awaddr/araddr, wb_dat_i into wdata and wb_sel_i into wstrb.
  - Go to WRITE (we=1) or READ (we=0).
  - awvalid/wvalid or arvalid assert on the next cycle.
  - wb_sel_i = 0 is passed through unchanged.
- WRITE:
  - awvalid and wvalid both rise on entry.
  - Each drops independently the cycle after its own ready handshake; AW and W may complete in either order or together.
  - Once both are done, go to WR_RESP.
  - No valid is deasserted before its handshake.
- WR_RESP:
  - bready = 1.
  - On bvalid, go to DONE with err = bresp[1].
- READ:
  - arvalid held until arready; then go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid, register rdata into wb_dat_o (also on error) and go to DONE with err = rresp[1].
- DONE:
  - Exactly one of wb_ack_o/wb_err_o high for one cycle, then IDLE.
  - OKAY and EXOKAY give ack; SLVERR and DECERR give err.
- Minimum latency, accept to ack, with AXI responding immediately: write 4 cycles (accept C0, AW+W handshake C1, B C2, ack C3); read 4 cycles.
- wb_dat_o holds the last read value until the next read completes; writes do not change it.
- wb_cyc_i dropped mid-transaction:
  - The AXI transaction always completes; AXI cannot be aborted.
  - The ack/err pulse for that transaction is suppressed.
  - The bridge returns to IDLE normally.
- A new request presented while stalled is not accepted until IDLE; the master must hold stb.
- An unexpected bvalid or rvalid outside its state is ignored (ready stays 0).

Test Plan:
- Write, addr 0x0000_0410 (wb_adr 0x104), data 0xDEAD_BEEF, sel 0xF, awready/wready/bvalid immediate with bresp 0 -> awaddr 0x410, wstrb 0xF, single wb_ack_o at C3, stall high for C1-C3.
- Write with wready asserted 3 cycles before awready, bresp 2'b10 -> wvalid drops first, awvalid is held, single wb_err_o, no ack.
- Read, addr 0x20, arready delayed 5 cycles, rdata 0x1234_5678, rresp 0 -> arvalid stable for 5 cycles, wb_dat_o = 0x1234_5678 together with ack.
- Read with rresp 2'b11 and rdata 0xAAAA_5555 -> wb_err_o pulse and wb_dat_o = 0xAAAA_5555.
- Write with wb_cyc_i dropped in WR_RESP, bvalid 4 cycles later -> bready handshake completes, no ack/err, and the next read is accepted and acked normally.
- rst_ni pulsed low mid-WRITE -> all AXI valids drop immediately, wb_stall_o = 0, wb_dat_o = 0.
